// File: rtl/dct_pass_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : dct_pass_sequencer_if
//  Purpose  : Row-stream input, shared 1-D DCT datapath and result-stream
//             signals of the 2-D DCT pass sequencer.
//  Revision : 1.0
// ============================================================================
interface dct_pass_sequencer_if #(
    parameter int DW = 32,
    parameter int N  = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_data;
    logic            dp_en;
    logic [N*DW-1:0] dp_in;
    logic            dp_valid;
    logic [N*DW-1:0] dp_out;
    logic            out_valid;
    logic            out_ready;
    logic [N*DW-1:0] out_data;
    logic            out_last;

    // Sequencer side
    modport master (
        input  in_valid, in_data, dp_valid, dp_out, out_ready,
        output in_ready, dp_en, dp_in, out_valid, out_data, out_last
    );

    // Front end, datapath and downstream side
    modport slave (
        output in_valid, in_data, dp_valid, dp_out, out_ready,
        input  in_ready, dp_en, dp_in, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/dct_pass_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dct_pass_sequencer
//  Purpose  : Runs one pipelined 1-D DCT datapath through the row pass, the
//             column pass and the result drain of an 8x8 2-D DCT.
//  Revision : 1.0
// ============================================================================
module dct_pass_sequencer #(
    parameter int DW  = 32,
    parameter int N   = 8,
    parameter int LAT = 14
) (
    input  wire                  clk,
    input  wire                  reset,
    dct_pass_sequencer_if.master bus,
    output logic                 busy,
    output logic                 err
);
    localparam int             CW   = $clog2(N);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        ROW_ISSUE = 3'd0,
        ROW_DRAIN = 3'd1,
        COL_ISSUE = 3'd2,
        COL_DRAIN = 3'd3,
        OUTPUT    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   row_cnt_q, row_cnt_d;
    logic [CW-1:0]   col_cnt_q, col_cnt_d;
    logic [CW-1:0]   beat_q, beat_d;
    logic [LAT-1:0]  tag_q, tag_d;
    logic [CW-1:0]   idx_q [LAT];
    logic [CW-1:0]   idx_d [LAT];
    logic            in_ready_q, in_ready_d;
    logic            dp_en_q, dp_en_d;
    logic [N*DW-1:0] dp_in_q, dp_in_d;
    logic            out_valid_q, out_valid_d;
    logic [N*DW-1:0] out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    logic [DW-1:0]   tbuf_q [N][N];
    logic [DW-1:0]   tbuf_d [N][N];
    logic [N*DW-1:0] rbuf_q [N];
    logic [N*DW-1:0] rbuf_d [N];

    logic            capture;
    logic [CW-1:0]   cap_idx;
    logic            tag_in;
    logic [CW-1:0]   idx_in;
    logic [CW-1:0]   beat_nx;
    logic [N*DW-1:0] col_row;

    // The tag leaving the pipe marks the cycle the datapath result is due.
    assign capture = dp_en_q & tag_q[LAT-1];
    assign cap_idx = idx_q[LAT-1];
    assign beat_nx = beat_q + 1'b1;

    always_comb begin
        col_row = '0;
        for (int r = 0; r < N; r++) begin
            col_row[r*DW +: DW] = tbuf_q[r][col_cnt_q];
        end
    end

    // Row-pass results fill the transpose buffer, column-pass results the result buffer.
    always_comb begin
        tbuf_d = tbuf_q;
        rbuf_d = rbuf_q;
        if (capture) begin
            if (state_q == ROW_ISSUE || state_q == ROW_DRAIN) begin
                for (int k = 0; k < N; k++) begin
                    tbuf_d[cap_idx][k] = bus.dp_out[k*DW +: DW];
                end
            end else begin
                rbuf_d[cap_idx] = bus.dp_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        tbuf_q <= tbuf_d;
        rbuf_q <= rbuf_d;
    end

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        col_cnt_d   = col_cnt_q;
        beat_d      = beat_q;
        dp_in_d     = dp_in_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        err_d       = err_q | (capture & ~bus.dp_valid);
        tag_in      = 1'b0;
        idx_in      = '0;

        case (state_q)
            ROW_ISSUE: begin
                if (bus.in_valid && in_ready_q) begin
                    dp_in_d   = bus.in_data;
                    tag_in    = 1'b1;
                    idx_in    = row_cnt_q;
                    row_cnt_d = row_cnt_q + 1'b1;
                    if (row_cnt_q == LAST) state_d = ROW_DRAIN;
                end
            end
            ROW_DRAIN: begin
                if (tag_q == '0) state_d = COL_ISSUE;
            end
            COL_ISSUE: begin
                dp_in_d   = col_row;
                tag_in    = 1'b1;
                idx_in    = col_cnt_q;
                col_cnt_d = col_cnt_q + 1'b1;
                if (col_cnt_q == LAST) state_d = COL_DRAIN;
            end
            COL_DRAIN: begin
                if (tag_q == '0) begin
                    state_d     = OUTPUT;
                    out_valid_d = 1'b1;
                    out_data_d  = rbuf_q[0];
                    out_last_d  = 1'b0;
                end
            end
            OUTPUT: begin
                if (out_valid_q && bus.out_ready) begin
                    if (beat_q == LAST) begin
                        state_d     = ROW_ISSUE;
                        beat_d      = '0;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_last_d  = 1'b0;
                    end else begin
                        beat_d     = beat_nx;
                        out_data_d = rbuf_q[beat_nx];
                        out_last_d = (beat_nx == LAST);
                    end
                end
            end
            default: state_d = ROW_ISSUE;
        endcase

        tag_d = tag_q;
        idx_d = idx_q;
        if (dp_en_q) begin
            tag_d    = {tag_q[LAT-2:0], tag_in};
            idx_d[0] = idx_in;
            for (int i = 1; i < LAT; i++) begin
                idx_d[i] = idx_q[i-1];
            end
        end

        // Outputs are decoded from the next state so they leave as flops.
        in_ready_d = (state_d == ROW_ISSUE);
        dp_en_d    = (state_d != OUTPUT);
        busy_d     = !((state_d == ROW_ISSUE) && (row_cnt_d == '0));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ROW_ISSUE;
            row_cnt_q   <= '0;
            col_cnt_q   <= '0;
            beat_q      <= '0;
            tag_q       <= '0;
            for (int i = 0; i < LAT; i++) begin
                idx_q[i] <= '0;
            end
            in_ready_q  <= 1'b0;
            dp_en_q     <= 1'b0;
            dp_in_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            col_cnt_q   <= col_cnt_d;
            beat_q      <= beat_d;
            tag_q       <= tag_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            dp_en_q     <= dp_en_d;
            dp_in_q     <= dp_in_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.dp_en     = dp_en_q;
    assign bus.dp_in     = dp_in_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign busy          = busy_q;
    assign err           = err_q;
endmodule
`default_nettype wire
